// File: rtl/bsg_fsb_node_boot_sequencer.sv
// bsg_fsb_node_boot_sequencer
//
// Master-side controller that brings a contiguous range of FSB nodes up and
// down by issuing switch (command) packets on one FSB injection port.
// Boot order per range: reset-on to all nodes, enable-on to all nodes, a hold
// delay, then reset-off to all nodes. Shutdown: enable-off to all nodes, then
// reset-on to all nodes.
//
// Ports:
//   clk_i       clock
//   reset_i     synchronous, active-high reset
//   start_i     level request to run the boot sequence (IDLE or DONE only)
//   shutdown_i  level request to run the shutdown sequence (DONE only)
//   v_o         packet valid toward the FSB
//   data_o      switch packet: {dest id, cmd=1, opcode[2:0], zeros}
//   ready_i     FSB accepts data_o when v_o & ready_i
//   busy_o      a sequence is in progress
//   done_o      all nodes booted (enabled and out of reset)

module bsg_fsb_node_boot_sequencer #(
  parameter int unsigned width_p       = 16,
  parameter int unsigned id_width_p    = 5,
  parameter int unsigned num_nodes_p   = 4,
  parameter int unsigned base_id_p     = 0,
  parameter int unsigned hold_cycles_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               shutdown_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned IdxW  = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;
  localparam int unsigned HoldW = $clog2(hold_cycles_p + 1);

  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(num_nodes_p - 1);
  localparam logic [HoldW-1:0]      HoldLoad = HoldW'(hold_cycles_p);
  localparam logic [id_width_p-1:0] BaseId   = id_width_p'(base_id_p);

  localparam logic [2:0] OpEnOn   = 3'b010;
  localparam logic [2:0] OpEnOff  = 3'b001;
  localparam logic [2:0] OpRstOn  = 3'b101;
  localparam logic [2:0] OpRstOff = 3'b110;

  typedef enum logic [2:0] {
    StIdle,
    StRstOn,
    StEnOn,
    StHold,
    StRstOff,
    StDone,
    StSdEnOff,
    StSdRstOn
  } state_e;

  state_e            state_q;
  state_e            phase_next;
  logic [IdxW-1:0]   idx_q;
  logic [HoldW-1:0]  hold_q;
  logic [2:0]        op;
  logic [id_width_p-1:0] node_id;

  // State that follows a packet phase once the last node has accepted.
  always_comb begin
    phase_next = StIdle;
    case (state_q)
      StRstOn:   phase_next = StEnOn;
      StEnOn:    phase_next = StHold;
      StRstOff:  phase_next = StDone;
      StSdEnOff: phase_next = StSdRstOn;
      StSdRstOn: phase_next = StIdle;
      default:   phase_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) state_q <= StRstOn;
        end
        StRstOn, StEnOn, StRstOff, StSdEnOff, StSdRstOn: begin
          if (ready_i) begin
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= phase_next;
              // Hold delay starts counting from the last enable-on handshake.
              if (state_q == StEnOn) hold_q <= HoldLoad;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StHold: begin
          // Leave one cycle after the counter reaches zero: hold_cycles_p+1 cycles total.
          if (hold_q == '0) state_q <= StRstOff;
          else              hold_q  <= hold_q - HoldW'(1);
        end
        StDone: begin
          if (shutdown_i)   state_q <= StSdEnOff;
          else if (start_i) state_q <= StRstOn;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign node_id = BaseId + id_width_p'(idx_q);

  // Outputs depend on registered state only; ready_i never reaches them.
  always_comb begin
    v_o = 1'b0;
    op  = 3'b000;
    case (state_q)
      StRstOn:   begin v_o = 1'b1; op = OpRstOn;  end
      StEnOn:    begin v_o = 1'b1; op = OpEnOn;   end
      StRstOff:  begin v_o = 1'b1; op = OpRstOff; end
      StSdEnOff: begin v_o = 1'b1; op = OpEnOff;  end
      StSdRstOn: begin v_o = 1'b1; op = OpRstOn;  end
      default:   begin v_o = 1'b0; op = 3'b000;   end
    endcase
  end

  always_comb begin
    data_o = '0;
    if (v_o) begin
      data_o[width_p-1 -: id_width_p]            = node_id;
      data_o[width_p-id_width_p-1]               = 1'b1;
      data_o[width_p-id_width_p-2 -: 3]          = op;
    end
  end

  assign busy_o = (state_q != StIdle) && (state_q != StDone);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_bsg_fsb_node_boot_sequencer.sv
// Bench for bsg_fsb_node_boot_sequencer: expected packets are queued when a
// sequence is requested; a monitor pops and compares on every handshake and
// feeds a per-node gateway model.

module tb_bsg_fsb_node_boot_sequencer;

  localparam int W    = 16;
  localparam int IDW  = 5;
  localparam int N    = 4;
  localparam int BASE = 2;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         reset_i, start_i, shutdown_i, ready_i;
  logic         v_o, busy_o, done_o;
  logic [W-1:0] data_o;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  bit           node_en[N];
  bit           node_rst[N];
  bit           rand_ready = 1'b0;

  bsg_fsb_node_boot_sequencer #(
    .width_p      (W),
    .id_width_p   (IDW),
    .num_nodes_p  (N),
    .base_id_p    (BASE),
    .hold_cycles_p(HOLD)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .shutdown_i(shutdown_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pkt(input int id, input int op);
    return W'((id << (W - IDW)) | (1 << (W - IDW - 1)) | (op << (W - IDW - 4)));
  endfunction

  task automatic push_phase(input int op);
    for (int i = 0; i < N; i++) exp_q.push_back(pkt(BASE + i, op));
  endtask

  task automatic push_boot();
    push_phase(3'b101);
    push_phase(3'b010);
    push_phase(3'b110);
  endtask

  task automatic push_shutdown();
    push_phase(3'b001);
    push_phase(3'b101);
  endtask

  task automatic chk_nodes(input string tag, input bit en, input bit rst);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_en"}, 64'(node_en[i]), 64'(en));
      chk({tag, "_rst"}, 64'(node_rst[i]), 64'(rst));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for done_o; n counts clock edges since the edge that sampled start.
  task automatic wait_done(input int budget, input bit check_busy, inout int n);
    while (!done_o && n < budget) begin
      if (check_busy) chk("busy_during_boot", 64'(busy_o), 64'd1);
      cycle();
      n++;
    end
    chk("done_reached", 64'(done_o), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_o || done_o) && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
  endtask

  // Random backpressure: ready about 30% of cycles while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) ready_i = ($urandom_range(0, 99) < 30);
    end
  end

  // Monitor: scoreboard compare, stability under backpressure, hold gap, gateways.
  initial begin
    bit           pend;
    logic [W-1:0] pend_data;
    bit           gap_on;
    int           gap_cnt;
    bit           done_prev;
    logic [W-1:0] e;
    int           id, op, k;
    pend = 0; gap_on = 0; gap_cnt = 0; done_prev = 0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        pend = 0;
        gap_on = 0;
        done_prev = 0;
        continue;
      end
      if (pend) begin
        chk("stall_v_stable", 64'(v_o), 64'd1);
        chk("stall_data_stable", 64'(data_o), 64'(pend_data));
      end
      if (gap_on) begin
        if (!v_o) gap_cnt++;
        else begin
          chk("hold_gap_cycles", 64'(gap_cnt), 64'(HOLD + 1));
          gap_on = 0;
        end
      end
      if (v_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pkt: got %0h expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("pkt", 64'(data_o), 64'(e));
        end
        id = int'(data_o >> (W - IDW));
        op = int'((data_o >> (W - IDW - 4)) & 7);
        k  = id - BASE;
        if (k >= 0 && k < N) begin
          case (op)
            3'b010: node_en[k]  = 1'b1;
            3'b001: node_en[k]  = 1'b0;
            3'b101: node_rst[k] = 1'b1;
            3'b110: node_rst[k] = 1'b0;
            default: ;
          endcase
        end
        if (op == 3'b010 && id == BASE + N - 1) begin
          gap_on = 1;
          gap_cnt = 0;
        end
      end
      pend = v_o && !ready_i;
      pend_data = data_o;
      if (done_o && !done_prev) chk("done_after_all_pkts", 64'(exp_q.size()), 64'd0);
      done_prev = done_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      node_en[i] = 1'b0;
      node_rst[i] = 1'b0;
    end
    reset_i = 1'b1; start_i = 1'b0; shutdown_i = 1'b0; ready_i = 1'b1;
    repeat (2) cycle();
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    reset_i = 1'b0;
    cycle();

    // Boot with ready tied high: latency and order.
    push_boot();
    pulse_start();
    chk("first_v", 64'(v_o), 64'd1);
    chk("first_data", 64'(data_o), 64'(pkt(BASE, 3'b101)));
    n = 1;
    wait_done(200, 1'b1, n);
    chk("boot_latency", 64'(n), 64'(3 * N + HOLD + 2));
    chk("done_not_busy", 64'(busy_o), 64'd0);
    chk_nodes("boot1", 1'b1, 1'b0);

    // Shutdown from DONE.
    repeat (3) cycle();
    push_shutdown();
    shutdown_i = 1'b1;
    cycle();
    shutdown_i = 1'b0;
    chk("sd_first_data", 64'(data_o), 64'(pkt(BASE, 3'b001)));
    wait_idle(200);
    chk_nodes("sd1", 1'b0, 1'b1);

    // Shutdown in IDLE is ignored.
    shutdown_i = 1'b1;
    repeat (3) cycle();
    shutdown_i = 1'b0;
    repeat (4) cycle();
    chk("idle_sd_v", 64'(v_o), 64'd0);
    chk("idle_sd_busy", 64'(busy_o), 64'd0);

    // Boot under random backpressure, with a stray start mid-sequence.
    rand_ready = 1'b1;
    push_boot();
    pulse_start();
    repeat (10) cycle();
    pulse_start();
    n = 1;
    wait_done(3000, 1'b0, n);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_nodes("boot2", 1'b1, 1'b0);
    rand_ready = 1'b0;
    ready_i = 1'b1;
    repeat (3) cycle();

    // Start and shutdown together in DONE: shutdown wins.
    push_shutdown();
    start_i = 1'b1;
    shutdown_i = 1'b1;
    cycle();
    start_i = 1'b0;
    shutdown_i = 1'b0;
    chk("both_busy", 64'(busy_o), 64'd1);
    chk("both_data", 64'(data_o), 64'(pkt(BASE, 3'b001)));
    wait_idle(200);
    chk_nodes("sd2", 1'b0, 1'b1);

    // Reset mid-boot during enable-on at the third node.
    push_boot();
    pulse_start();
    repeat (6) cycle();
    ready_i = 1'b0;
    cycle();
    chk("mid_v", 64'(v_o), 64'd1);
    chk("mid_data", 64'(data_o), 64'(pkt(BASE + 2, 3'b010)));
    reset_i = 1'b1;
    exp_q.delete();
    cycle();
    chk("abort_v", 64'(v_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_data", 64'(data_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    reset_i = 1'b0;
    ready_i = 1'b1;
    cycle();
    push_boot();
    pulse_start();
    chk("restart_data", 64'(data_o), 64'(pkt(BASE, 3'b101)));
    n = 1;
    wait_done(200, 1'b1, n);
    chk("restart_latency", 64'(n), 64'(3 * N + HOLD + 2));
    chk_nodes("boot3", 1'b1, 1'b0);
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
